// File: rtl/imem_uart_loader.sv
// UART program loader for the CPU instruction memory. It receives 8N1 bytes, checks an A5/length header,
// packs little-endian 32-bit words into IM writes, and holds the CPU in reset while a load is active.
module imem_uart_loader #(
  parameter int unsigned CLK_FREQ    = 100_000_000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned ADDR_WIDTH  = 6,
  parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_rx,
  input  logic                  load_en,
  output logic                  im_we,
  output logic [ADDR_WIDTH-1:0] im_addr,
  output logic [31:0]           im_wdata,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_err,
  output logic [ADDR_WIDTH:0]   word_cnt
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [31:0]   CAPACITY  = 32'd1 << ADDR_WIDTH;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {LD_IDLE, LD_LEN, LD_DATA, LD_DONE, LD_ERR} ld_state_t;

  rx_state_t rx_state, rx_state_d;
  logic rx_s1, rx_s2, rx_s3;
  logic [CW-1:0] rx_cnt;
  logic [2:0] rx_bit;
  logic [7:0] rx_byte;
  logic rx_cnt_clr, rx_sample, byte_valid, frame_err;

  // rx_s3 is the previous synchronised level, used only for start-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      {rx_s1, rx_s2, rx_s3} <= 3'b111;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_byte  <= '0;
    end else begin
      {rx_s1, rx_s2, rx_s3} <= {uart_rx, rx_s1, rx_s2};
      rx_state <= rx_state_d;
      rx_cnt   <= rx_cnt_clr ? '0 : rx_cnt + 1'b1;
      if (rx_state != RX_DATA) rx_bit <= '0;
      else if (rx_sample) rx_bit <= rx_bit + 1'b1;
      if (rx_sample) rx_byte <= {rx_s2, rx_byte[7:1]};
    end
  end

  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_clr = 1'b0;
    rx_sample  = 1'b0;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (rx_state)
      RX_IDLE: if (rx_s3 && !rx_s2) begin
        rx_state_d = RX_START;
        rx_cnt_clr = 1'b1;
      end
      RX_START: if (rx_cnt == HALF_LAST) begin
        rx_cnt_clr = 1'b1;
        rx_state_d = rx_s2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt == BIT_LAST) begin
        rx_cnt_clr = 1'b1;
        rx_sample  = 1'b1;
        if (rx_bit == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_cnt == BIT_LAST) begin
        rx_cnt_clr = 1'b1;
        rx_state_d = RX_IDLE;
        if (rx_s2) byte_valid = 1'b1;
        else frame_err = 1'b1;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  ld_state_t ld_state, ld_state_d;
  logic [7:0] len;
  logic [1:0] byte_idx;
  logic [23:0] word_buf;
  logic [TW-1:0] tmo_cnt;
  logic start_load, accept_len, accept_data, write_word, tmo_hit, loading;
  logic [ADDR_WIDTH:0] word_cnt_nxt;

  assign loading      = (ld_state == LD_LEN) || (ld_state == LD_DATA);
  assign tmo_hit      = loading && (tmo_cnt >= TMO_LAST);
  assign word_cnt_nxt = word_cnt + 1'b1;

  always_comb begin
    ld_state_d  = ld_state;
    start_load  = 1'b0;
    accept_len  = 1'b0;
    accept_data = 1'b0;
    write_word  = 1'b0;
    case (ld_state)
      LD_IDLE, LD_DONE: begin
        if (!load_en) ld_state_d = LD_IDLE;
        else if (byte_valid && rx_byte == 8'hA5) begin
          ld_state_d = LD_LEN;
          start_load = 1'b1;
        end
      end
      LD_LEN: begin
        if (!load_en) ld_state_d = LD_IDLE;
        else if (frame_err || tmo_hit) ld_state_d = LD_ERR;
        else if (byte_valid) begin
          if (rx_byte == 8'd0 || {24'd0, rx_byte} > CAPACITY) ld_state_d = LD_ERR;
          else begin
            ld_state_d = LD_DATA;
            accept_len = 1'b1;
          end
        end
      end
      LD_DATA: begin
        if (!load_en) ld_state_d = LD_IDLE;
        else if (frame_err || tmo_hit) ld_state_d = LD_ERR;
        else if (byte_valid) begin
          accept_data = 1'b1;
          if (byte_idx == 2'd3) begin
            write_word = 1'b1;
            if (32'(word_cnt_nxt) == 32'(len)) ld_state_d = LD_DONE;
          end
        end
      end
      LD_ERR: if (!load_en) ld_state_d = LD_IDLE;
      default: ld_state_d = LD_IDLE;
    endcase
  end

  // The write strobe, address and data are registered, so the IM write lands the cycle after the 4th byte
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_state  <= LD_IDLE;
      len       <= '0;
      byte_idx  <= '0;
      word_buf  <= '0;
      tmo_cnt   <= '0;
      im_we     <= 1'b0;
      im_addr   <= '0;
      im_wdata  <= '0;
      cpu_hold  <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      word_cnt  <= '0;
    end else begin
      ld_state <= ld_state_d;
      im_we    <= write_word;
      cpu_hold <= loading || (ld_state == LD_ERR);
      if (!loading || byte_valid || ld_state_d != ld_state) tmo_cnt <= '0;
      else tmo_cnt <= tmo_cnt + 1'b1;
      if (start_load) begin
        load_done <= 1'b0;
        load_err  <= 1'b0;
        word_cnt  <= '0;
      end
      if (accept_len) begin
        len      <= rx_byte;
        byte_idx <= '0;
      end
      if (accept_data) begin
        byte_idx <= byte_idx + 1'b1;
        if (byte_idx != 2'd3) word_buf[byte_idx*8 +: 8] <= rx_byte;
      end
      if (write_word) begin
        im_addr  <= word_cnt[ADDR_WIDTH-1:0];
        im_wdata <= {rx_byte, word_buf};
        word_cnt <= word_cnt_nxt;
      end
      if (ld_state_d == LD_DONE && ld_state != LD_DONE) load_done <= 1'b1;
      if (ld_state_d == LD_ERR && ld_state != LD_ERR) load_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader: serial frames in, IM writes checked through an expected-write queue.
module tb_imem_uart_loader;

  logic        clk;
  logic        rst;
  logic        uart_rx;
  logic        load_en;
  logic        im_we;
  logic [5:0]  im_addr;
  logic [31:0] im_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [6:0]  word_cnt;

  imem_uart_loader #(
    .CLK_FREQ(16), .BAUD(1), .ADDR_WIDTH(6), .TIMEOUT_CYC(2000)
  ) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .load_en(load_en),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err),
    .word_cnt(word_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int we_count = 0;
  logic [37:0] exp_q[$];
  logic [37:0] exp_w;

  logic [7:0] prog[10] = '{8'hA5, 8'h02, 8'h13, 8'h05, 8'h00, 8'h00, 8'hB3, 8'h02, 8'h50, 8'h00};

  // scoreboard monitor: every IM write must match the head of the expected queue
  always @(negedge clk) begin
    if (im_we) begin
      we_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual addr=%0h data=%08h required no write", im_addr, im_wdata);
      end else begin
        exp_w = exp_q.pop_front();
        if ({im_addr, im_wdata} !== exp_w) begin
          errors++;
          $display("FAIL im_write actual addr=%0h data=%08h required addr=%0h data=%08h",
                   im_addr, im_wdata, exp_w[37:32], exp_w[31:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // driver: one 8N1 frame at 16 clocks per bit, stop bit level selectable
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    uart_rx = 1'b0;
    wait_clks(16);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_clks(16);
    end
    uart_rx = stop_bit;
    wait_clks(16);
    uart_rx = 1'b1;
    wait_clks(2);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_clks(3);
    rst = 1'b0;
  endtask

  initial begin
    int base;
    uart_rx = 1'b1;
    load_en = 1'b0;
    rst     = 1'b1;
    wait_clks(3);
    check("reset_im_we", 32'(im_we), 0);
    check("reset_outputs", {im_addr, cpu_hold, load_done, load_err, word_cnt}, 0);
    check("reset_wdata", im_wdata, 0);
    rst = 1'b0;
    wait_clks(1000);
    check("idle_no_writes", we_count, 0);

    // full two-word load
    load_en = 1'b1;
    exp_q.push_back({6'd0, 32'h0000_0513});
    exp_q.push_back({6'd1, 32'h0050_02B3});
    send_byte(prog[0], 1'b1);
    send_byte(prog[1], 1'b1);
    wait_clks(2);
    check("load_cpu_hold_on", 32'(cpu_hold), 1);
    for (int i = 2; i < 10; i++) send_byte(prog[i], 1'b1);
    wait_clks(3);
    check("load_word_cnt", 32'(word_cnt), 2);
    check("load_done", 32'(load_done), 1);
    check("load_err_clear", 32'(load_err), 0);
    check("load_cpu_hold_off", 32'(cpu_hold), 0);
    check("load_writes", we_count, 2);

    // IDLE ignores non-header bytes and a short glitch
    do_reset();
    base = we_count;
    load_en = 1'b1;
    send_byte(8'h00, 1'b1);
    send_byte(8'h37, 1'b1);
    @(negedge clk);
    uart_rx = 1'b0;
    wait_clks(4);
    uart_rx = 1'b1;
    wait_clks(40);
    check("idle_glitch_writes", we_count - base, 0);
    check("idle_cpu_hold", 32'(cpu_hold), 0);
    check("idle_done_err", {load_done, load_err}, 0);

    // framing error in a load
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h13, 1'b0);
    wait_clks(3);
    check("ferr_load_err", 32'(load_err), 1);
    check("ferr_cpu_hold", 32'(cpu_hold), 1);
    check("ferr_word_cnt", 32'(word_cnt), 0);
    check("ferr_writes", we_count - base, 0);
    load_en = 1'b0;
    wait_clks(3);
    check("ferr_release_hold", 32'(cpu_hold), 0);
    check("ferr_err_sticky", 32'(load_err), 1);

    // inter-byte timeout with a partial word pending
    load_en = 1'b1;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h13, 1'b1);
    send_byte(8'h05, 1'b1);
    wait_clks(1900);
    check("tmo_not_yet", 32'(load_err), 0);
    wait_clks(200);
    check("tmo_load_err", 32'(load_err), 1);
    check("tmo_cpu_hold", 32'(cpu_hold), 1);
    check("tmo_writes", we_count - base, 0);
    load_en = 1'b0;
    wait_clks(3);

    // length boundaries: zero and one past capacity
    load_en = 1'b1;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    wait_clks(3);
    check("len0_err", 32'(load_err), 1);
    load_en = 1'b0;
    wait_clks(3);
    load_en = 1'b1;
    send_byte(8'hA5, 1'b1);
    send_byte(8'd65, 1'b1);
    wait_clks(3);
    check("len65_err", 32'(load_err), 1);
    check("len65_done", 32'(load_done), 0);
    load_en = 1'b0;
    wait_clks(3);

    // abort after one word plus one byte
    load_en = 1'b1;
    exp_q.push_back({6'd0, 32'h0000_0513});
    base = we_count;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    for (int i = 2; i < 7; i++) send_byte(prog[i], 1'b1);
    load_en = 1'b0;
    wait_clks(3);
    check("abort_writes", we_count - base, 1);
    check("abort_cpu_hold", 32'(cpu_hold), 0);
    check("abort_done_err", {load_done, load_err}, 0);
    check("abort_word_cnt", 32'(word_cnt), 1);
    wait_clks(200);
    check("abort_no_more_writes", we_count - base, 1);
    check("exp_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
